// File: rtl/counter_seq_pkg.sv
// Shared types and command encodings for the counter sequencer.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_UP   = 2'd1,
    ST_RUN_DOWN = 2'd2,
    ST_PAUSED   = 2'd3
  } state_e;

  localparam logic [1:0] OP_START_UP   = 2'd0;
  localparam logic [1:0] OP_START_DOWN = 2'd1;
  localparam logic [1:0] OP_PAUSE      = 2'd2;
  localparam logic [1:0] OP_STOP       = 2'd3;

endpackage

// File: rtl/counter_sequencer_tick_gen.sv
// Step-enable generator: one registered tick every DIV_MAX+1 enabled cycles.
module tick_gen #(
  parameter int unsigned DIV_MAX = 49999999
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_MAX);
  localparam logic [DW-1:0] DIV_ONE  = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] r_div_cnt;
  logic          r_tick;

  // Divider counter; holds when disabled so a resumed run keeps its phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (clr) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (en) begin
      if (r_div_cnt == DIV_LAST) begin
        r_div_cnt <= '0;
        r_tick    <= 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_ONE;
        r_tick    <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven bounded up/down counter with optional ping-pong reversal.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DIV_MAX = 49999999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             ping_pong,
  output logic [WIDTH-1:0] count,
  output logic             dir_up,
  output logic             busy,
  output logic             paused,
  output logic             tick,
  output logic             done,
  output logic             cmd_err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_limit;
  logic             r_dir_up;
  logic             r_done;
  logic             r_cmd_err;
  logic             r_cmd_ready;
  logic             r_busy;
  logic             r_paused;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_limit_nxt;
  logic             w_dir_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic             w_busy_nxt;
  logic             w_paused_nxt;
  logic             w_run;
  logic             w_cmd_acc;
  logic             w_start;
  logic             w_tick;

  assign w_run     = (r_state == ST_RUN_UP) || (r_state == ST_RUN_DOWN);
  assign w_cmd_acc = cmd_valid & r_cmd_ready;
  assign w_start   = w_cmd_acc & ((cmd_op == OP_START_UP) || (cmd_op == OP_START_DOWN));

  // Divider is frozen on a command edge so a pause never swallows a pending tick.
  tick_gen #(.DIV_MAX(DIV_MAX)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (w_run & ~w_cmd_acc),
    .clr  (w_start),
    .tick (w_tick)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_limit     <= '0;
      r_dir_up    <= 1'b1;
      r_done      <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_paused    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_limit     <= w_limit_nxt;
      r_dir_up    <= w_dir_nxt;
      r_done      <= w_done_nxt;
      r_cmd_err   <= w_err_nxt;
      r_cmd_ready <= 1'b1;
      r_busy      <= w_busy_nxt;
      r_paused    <= w_paused_nxt;
    end
  end

  // Next-state logic; an accepted command takes priority over a tick step.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_limit_nxt = r_limit;
    w_dir_nxt   = r_dir_up;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_cmd_acc) begin
      case (cmd_op)
        OP_START_UP, OP_START_DOWN: begin
          w_limit_nxt = cmd_limit;
          w_dir_nxt   = (cmd_op == OP_START_UP);
          w_count_nxt = (cmd_op == OP_START_UP) ? '0 : cmd_limit;
          if (cmd_limit == '0) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = (cmd_op == OP_START_UP) ? ST_RUN_UP : ST_RUN_DOWN;
          end
        end
        OP_PAUSE: begin
          case (r_state)
            ST_RUN_UP, ST_RUN_DOWN: w_state_nxt = ST_PAUSED;
            ST_PAUSED:              w_state_nxt = r_dir_up ? ST_RUN_UP : ST_RUN_DOWN;
            default:                w_err_nxt   = 1'b1;
          endcase
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_tick) begin
      case (r_state)
        ST_RUN_UP: begin
          w_count_nxt = r_count + ONE;
          if (w_count_nxt == r_limit) begin
            w_state_nxt = ping_pong ? ST_RUN_DOWN : ST_IDLE;
            w_dir_nxt   = ~ping_pong;
            w_done_nxt  = ~ping_pong;
          end else begin
            w_state_nxt = ST_RUN_UP;
          end
        end
        ST_RUN_DOWN: begin
          w_count_nxt = r_count - ONE;
          if (w_count_nxt == '0) begin
            w_state_nxt = ping_pong ? ST_RUN_UP : ST_IDLE;
            w_dir_nxt   = ping_pong;
            w_done_nxt  = ~ping_pong;
          end else begin
            w_state_nxt = ST_RUN_DOWN;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Status decode from the next state so busy/paused stay registered.
  always_comb begin
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
    w_paused_nxt = (w_state_nxt == ST_PAUSED);
  end

  assign cmd_ready = r_cmd_ready;
  assign count     = r_count;
  assign dir_up    = r_dir_up;
  assign busy      = r_busy;
  assign paused    = r_paused;
  assign tick      = w_tick;
  assign done      = r_done;
  assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with WIDTH=4, DIV_MAX=3 (tick every 4 cycles).
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_limit = 4'd0;
  logic       ping_pong = 1'b0;
  logic [3:0] count;
  logic       dir_up, busy, paused, tick, done, cmd_err;

  int errors = 0;
  int checks = 0;

  counter_sequencer #(.WIDTH(4), .DIV_MAX(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_limit(cmd_limit), .ping_pong(ping_pong),
    .count(count), .dir_up(dir_up), .busy(busy), .paused(paused),
    .tick(tick), .done(done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the edge that accepted the command.
  task automatic issue(input logic [1:0] op, input logic [3:0] lim);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_limit = lim;
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(2);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", cmd_ready); end
    checks++; if ({count, busy, done, dir_up, tick} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rst_state count=%0d busy=%b done=%b dir=%b tick=%b", count, busy, done, dir_up, tick); end
    rst = 1'b0;
    cyc(1);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise got=%b exp=1", cmd_ready); end
    ping_pong = 1'b0;
    issue(OP_START_UP, 4'd9);
    cyc(5);
    checks++; if (count !== 4'd1 || busy !== 1'b1) begin errors++; $display("FAIL pre_reset count=%0d busy=%b exp 1/1", count, busy); end
    rst = 1'b1;
    cyc(2);
    checks++; if ({count, busy, done, cmd_ready} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midrun_reset count=%0d busy=%b done=%b ready=%b", count, busy, done, cmd_ready); end
    rst = 1'b0;
    cyc(1);
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL post_reset ready=%b done=%b", cmd_ready, done); end
  endtask

  task automatic test_start_up;
    ping_pong = 1'b0;
    issue(OP_START_UP, 4'd5);
    checks++; if (count !== 4'd0 || busy !== 1'b1 || dir_up !== 1'b1) begin
      errors++; $display("FAIL up_start count=%0d busy=%b dir=%b", count, busy, dir_up); end
    for (int k = 1; k <= 5; k++) begin
      cyc((k == 1) ? 4 : 3);
      checks++; if (tick !== 1'b1 || count !== 4'(k - 1)) begin
        errors++; $display("FAIL up_tick k=%0d tick=%b count=%0d exp 1/%0d", k, tick, count, k - 1); end
      cyc(1);
      checks++; if (count !== 4'(k) || tick !== 1'b0) begin
        errors++; $display("FAIL up_step k=%0d count=%0d tick=%b exp %0d/0", k, count, tick, k); end
      checks++; if (done !== (k == 5)) begin errors++; $display("FAIL up_done k=%0d got=%b", k, done); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL up_busy got=%b exp=0", busy); end
    cyc(1);
    checks++; if (done !== 1'b0 || count !== 4'd5) begin errors++; $display("FAIL up_after done=%b count=%0d", done, count); end
  endtask

  task automatic test_ping_pong;
    logic [3:0] exp_cnt;
    logic       exp_dir;
    ping_pong = 1'b1;
    issue(OP_START_DOWN, 4'd15);
    checks++; if (count !== 4'd15 || dir_up !== 1'b0) begin errors++; $display("FAIL pp_start count=%0d dir=%b", count, dir_up); end
    for (int k = 1; k <= 31; k++) begin
      cyc((k == 1) ? 5 : 4);
      exp_cnt = (k <= 15) ? 4'(15 - k) : ((k <= 30) ? 4'(k - 15) : 4'(45 - k));
      exp_dir = (k >= 15) && (k <= 29);
      checks++; if (count !== exp_cnt || dir_up !== exp_dir || done !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL pp_step k=%0d count=%0d dir=%b done=%b busy=%b exp %0d/%b/0/1", k, count, dir_up, done, busy, exp_cnt, exp_dir); end
    end
    issue(OP_STOP, 4'd0);
    ping_pong = 1'b0;
  endtask

  task automatic test_pause;
    int bad;
    ping_pong = 1'b0;
    issue(OP_START_UP, 4'd9);
    cyc(13);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL pause_pre count=%0d exp=3", count); end
    issue(OP_PAUSE, 4'd0);
    checks++; if (paused !== 1'b1 || busy !== 1'b1 || count !== 4'd3) begin
      errors++; $display("FAIL pause_enter paused=%b busy=%b count=%0d", paused, busy, count); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (tick !== 1'b0 || count !== 4'd3) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL pause_hold bad_cycles=%0d exp=0", bad); end
    issue(OP_PAUSE, 4'd0);
    checks++; if (paused !== 1'b0 || busy !== 1'b1 || count !== 4'd3) begin
      errors++; $display("FAIL pause_resume paused=%b busy=%b count=%0d", paused, busy, count); end
    cyc(3);
    checks++; if (tick !== 1'b1 || count !== 4'd3) begin errors++; $display("FAIL pause_tick tick=%b count=%0d", tick, count); end
    cyc(1);
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL pause_step count=%0d exp=4", count); end
    issue(OP_STOP, 4'd0);
  endtask

  task automatic test_edge_cmds;
    issue(OP_START_UP, 4'd0);
    checks++; if (done !== 1'b1 || count !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL lim0 done=%b count=%0d busy=%b exp 1/0/0", done, count, busy); end
    cyc(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL lim0_pulse done=%b exp=0", done); end
    issue(OP_PAUSE, 4'd0);
    checks++; if (cmd_err !== 1'b1 || busy !== 1'b0 || paused !== 1'b0) begin
      errors++; $display("FAIL idle_pause err=%b busy=%b paused=%b exp 1/0/0", cmd_err, busy, paused); end
    cyc(1);
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL idle_pause_pulse err=%b exp=0", cmd_err); end
    issue(OP_START_UP, 4'd9);
    cyc(25);
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL stop_pre count=%0d exp=6", count); end
    issue(OP_STOP, 4'd0);
    checks++; if (busy !== 1'b0 || count !== 4'd6 || done !== 1'b0) begin
      errors++; $display("FAIL stop busy=%b count=%0d done=%b exp 0/6/0", busy, count, done); end
    cyc(8);
    checks++; if (count !== 4'd6 || done !== 1'b0 || tick !== 1'b0) begin
      errors++; $display("FAIL stop_hold count=%0d done=%b tick=%b", count, done, tick); end
  endtask

  task automatic test_collision;
    ping_pong = 1'b0;
    issue(OP_START_UP, 4'd9);
    cyc(4);
    checks++; if (tick !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL coll_tick tick=%b count=%0d exp 1/0", tick, count); end
    issue(OP_START_DOWN, 4'd7);
    checks++; if (count !== 4'd7 || dir_up !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL coll_start count=%0d dir=%b busy=%b exp 7/0/1", count, dir_up, busy); end
    cyc(4);
    checks++; if (count !== 4'd7 || tick !== 1'b1) begin errors++; $display("FAIL coll_wait count=%0d tick=%b exp 7/1", count, tick); end
    cyc(1);
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL coll_step count=%0d exp=6", count); end
    issue(OP_STOP, 4'd0);
  endtask

  initial begin
    test_reset();
    test_start_up();
    test_ping_pong();
    test_pause();
    test_edge_cmds();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
